// File: rtl/msft_dv_spi_apb_pkg.sv
// Shared types and bit positions for the SPI-to-APB debug bridge.
// Status flags are sticky and clear at the start of each frame.
package msft_dv_spi_apb_pkg;

  typedef enum logic [1:0] {
    A_IDLE,
    A_SETUP,
    A_ACCESS
  } apb_state_t;

  typedef enum logic [1:0] {
    F_IDLE,
    F_CMD,
    F_DATA
  } frame_state_t;

  // Command bit offsets counted down from the command MSB.
  localparam int CMD_WR_OFS   = 1;
  localparam int CMD_INCR_OFS = 2;

  localparam int ST_UNDER  = 0;
  localparam int ST_OVER   = 1;
  localparam int ST_SLVERR = 2;
  localparam int ST_TMO    = 3;

endpackage

// File: rtl/msft_dv_spi_sync_edge.sv
// Multi-flop synchroniser with single-cycle rise/fall strobes.
// RST_VAL sets the idle level so reset does not fake an edge.
module msft_dv_spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= {STAGES{RST_VAL}};
      prev <= RST_VAL;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign rise = sync[STAGES-1] & ~prev;
  assign fall = ~sync[STAGES-1] & prev;

endmodule

// File: rtl/msft_dv_spi_apb_bridge.sv
// Oversampled SPI slave (mode 0) driving an APB master with prefetch/bursts.
// Optional APB watchdog: define MSFTDV_SPI_APB_TIMEOUT_EN.
module msft_dv_spi_apb_bridge
  import msft_dv_spi_apb_pkg::*;
#(
  parameter int AW          = 16,
  parameter int DW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sclk,
  input  logic                         mosi,
  input  logic                         ss0n,
  output logic                         miso,
  output logic                         miso_oen,
  output logic                         psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [AW-3+$clog2(DW/8):0]   paddr,
  output logic [DW-1:0]                pwdata,
  input  logic [DW-1:0]                prdata,
  input  logic                         pready,
  input  logic                         pslverr,
  output logic                         busy,
  output logic [3:0]                   status
);

  localparam int WA = AW - 2;
  localparam int BA = $clog2(DW / 8);
  localparam int CW = $clog2(AW > DW ? AW : DW);

  if (SYNC_STAGES < 2 || (DW != 16 && DW != 32) || TIMEOUT < 1)
    $error("msft_dv_spi_apb_bridge: illegal parameters");

  logic ss_rise, ss_fall, sck_rise, sck_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sdi;

  frame_state_t fst, fst_n;
  apb_state_t   ast, ast_n;

  logic [CW-1:0] bit_cnt, tx_cnt;
  logic [AW-2:0] cmd_sh;
  logic [DW-2:0] rx_sh;
  logic [DW-1:0] rbuf, tx_sh;
  logic [WA-1:0] addr;
  logic is_wr, is_incr, rbuf_vld, pend, pend_wr;
  logic cmd_done, word_done, data_fall, load;
  logic start, done, tmo, wr_take, wr_drop;
  logic [3:0] st_set;

  msft_dv_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst(rst), .d(sclk), .rise(sck_rise), .fall(sck_fall)
  );

  msft_dv_spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk(clk), .rst(rst), .d(ss0n), .rise(ss_rise), .fall(ss_fall)
  );

  // Same depth as the sclk path, so sdi is valid on the detected rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mosi_sync <= '0;
    else     mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end
  assign sdi = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fst <= F_IDLE;
    else     fst <= fst_n;
  end

  always_comb begin
    fst_n = fst;
    if (ss_rise)       fst_n = F_IDLE;
    else if (ss_fall)  fst_n = F_CMD;
    else if (cmd_done) fst_n = F_DATA;
  end

  always_comb begin
    cmd_done  = 1'b0;
    word_done = 1'b0;
    data_fall = 1'b0;
    unique case (fst)
      F_CMD:  cmd_done = sck_rise && bit_cnt == CW'(AW-1);
      F_DATA: begin
        word_done = sck_rise && bit_cnt == CW'(DW-1);
        data_fall = sck_fall;
      end
      default: ;
    endcase
    load = data_fall && tx_cnt == '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ast <= A_IDLE;
    else     ast <= ast_n;
  end

  always_comb begin
    ast_n = ast;
    unique case (ast)
      A_IDLE:   if (pend) ast_n = A_SETUP;
      A_SETUP:  ast_n = A_ACCESS;
      A_ACCESS: if (pready || tmo) ast_n = A_IDLE;
      default:  ast_n = A_IDLE;
    endcase
  end

  always_comb begin
    psel    = ast != A_IDLE;
    penable = ast == A_ACCESS;
    busy    = ast != A_IDLE;
    start   = ast == A_IDLE && pend;
    done    = ast == A_ACCESS && pready;
  end

`ifdef MSFTDV_SPI_APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                tmo_cnt <= '0;
    else if (!penable)      tmo_cnt <= '0;
    else                    tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo = penable && !pready && tmo_cnt == TW'(TIMEOUT-1);
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    wr_take = word_done && is_wr && !busy && !pend;
    wr_drop = word_done && is_wr && (busy || pend);
    st_set = '0;
    st_set[ST_UNDER]  = load && !is_wr && !rbuf_vld;
    st_set[ST_OVER]   = wr_drop;
    st_set[ST_SLVERR] = done && pslverr;
    st_set[ST_TMO]    = tmo;
  end

  assign miso = tx_sh[DW-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      tx_cnt   <= '0;
      cmd_sh   <= '0;
      rx_sh    <= '0;
      is_wr    <= 1'b0;
      is_incr  <= 1'b0;
      addr     <= '0;
      pend     <= 1'b0;
      pend_wr  <= 1'b0;
      rbuf     <= '0;
      rbuf_vld <= 1'b0;
      tx_sh    <= '0;
      miso_oen <= 1'b0;
      paddr    <= '0;
      pwrite   <= 1'b0;
      pwdata   <= '0;
      status   <= '0;
    end else begin
      if (ss_fall || ss_rise || cmd_done || word_done)
        bit_cnt <= '0;
      else if (sck_rise && fst != F_IDLE)
        bit_cnt <= bit_cnt + 1'b1;

      if (ss_fall || ss_rise)
        tx_cnt <= '0;
      else if (data_fall)
        tx_cnt <= (tx_cnt == CW'(DW-1)) ? '0 : tx_cnt + 1'b1;

      if (sck_rise && fst == F_CMD)
        cmd_sh <= {cmd_sh[AW-3:0], sdi};
      if (sck_rise && fst == F_DATA)
        rx_sh <= {rx_sh[DW-3:0], sdi};

      if (cmd_done) begin
        is_wr   <= cmd_sh[AW-1-CMD_WR_OFS];
        is_incr <= cmd_sh[AW-1-CMD_INCR_OFS];
        addr    <= {cmd_sh[AW-4:0], sdi};
      end else if (start && is_incr) begin
        addr <= addr + 1'b1;
      end

      // A load that coincides with start re-arms pend for the next word.
      if (ss_rise) begin
        pend <= 1'b0;
      end else if (cmd_done && !cmd_sh[AW-1-CMD_WR_OFS]) begin
        pend    <= 1'b1;
        pend_wr <= 1'b0;
      end else if (wr_take) begin
        pend    <= 1'b1;
        pend_wr <= 1'b1;
        pwdata  <= {rx_sh, sdi};
      end else if (load && !is_wr) begin
        pend    <= 1'b1;
        pend_wr <= 1'b0;
      end else if (start) begin
        pend <= 1'b0;
      end

      if (start) begin
        paddr  <= {addr, {BA{1'b0}}};
        pwrite <= pend_wr;
      end

      if (ss_fall || load) rbuf_vld <= 1'b0;
      if (done && !pwrite) begin
        rbuf     <= prdata;
        rbuf_vld <= 1'b1;
      end

      if (data_fall) begin
        if (load) tx_sh <= rbuf_vld ? rbuf : '1;
        else      tx_sh <= {tx_sh[DW-2:0], 1'b1};
      end

      if (ss_rise)        miso_oen <= 1'b0;
      else if (data_fall) miso_oen <= 1'b1;

      status <= (ss_fall ? 4'b0 : status) | st_set;
    end
  end

endmodule
